// File: rtl/samsun_lsu_if.sv
// rtl/samsun_lsu_if.sv - execute-stage request/response and data-memory port bundle for samsun_lsu
interface samsun_lsu_if;
   // execute-stage side
   logic        lsu_valid_i;
   logic        lsu_ready_o;
   logic        lsu_we_i;
   logic [2:0]  lsu_funct3_i;
   logic [31:0] lsu_addr_i;
   logic [31:0] lsu_wdata_i;
   logic        lsu_rvalid_o;
   logic [31:0] lsu_rdata_o;
   logic        lsu_misalign_o;
   // data-memory side
   logic        dmem_req_o;
   logic        dmem_wen_o;
   logic [3:0]  dmem_be_o;
   logic [31:0] dmem_addr_o;
   logic [31:0] dmem_wdata_o;
   logic [31:0] dmem_rdata_i;

   // the LSU itself
   modport slave (
      input  lsu_valid_i, lsu_we_i, lsu_funct3_i, lsu_addr_i, lsu_wdata_i, dmem_rdata_i,
      output lsu_ready_o, lsu_rvalid_o, lsu_rdata_o, lsu_misalign_o,
      output dmem_req_o, dmem_wen_o, dmem_be_o, dmem_addr_o, dmem_wdata_o
   );

   // the execute stage plus data memory surrounding the LSU
   modport master (
      output lsu_valid_i, lsu_we_i, lsu_funct3_i, lsu_addr_i, lsu_wdata_i, dmem_rdata_i,
      input  lsu_ready_o, lsu_rvalid_o, lsu_rdata_o, lsu_misalign_o,
      input  dmem_req_o, dmem_wen_o, dmem_be_o, dmem_addr_o, dmem_wdata_o
   );
endinterface

// File: rtl/samsun_lsu.sv
// rtl/samsun_lsu.sv - single-outstanding RV32I load/store unit with fixed-latency data memory
module samsun_lsu #(
   parameter int DMEM_LATENCY = 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   samsun_lsu_if.slave   lsu
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   // wait counter reloads with latency-1 so the capture lands exactly on the data cycle
   localparam logic [1:0] CNT_INIT = 2'(DMEM_LATENCY - 1);

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        fault_q, fault_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] word_q, word_d;

   logic        accept;
   logic        fault_in;
   logic [3:0]  be_calc;
   logic [31:0] lane_data;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [31:0] load_ext;

   assign lsu.lsu_ready_o = (state_q == S_IDLE) && !rst_i;
   assign accept          = lsu.lsu_valid_i && lsu.lsu_ready_o;

   // classify the incoming request; faulting requests never reach memory
   always_comb begin
      fault_in = 1'b0;
      case (lsu.lsu_funct3_i)
         3'b000:  fault_in = 1'b0;
         3'b001:  fault_in = lsu.lsu_addr_i[0];
         3'b010:  fault_in = |lsu.lsu_addr_i[1:0];
         3'b100:  fault_in = lsu.lsu_we_i;
         3'b101:  fault_in = lsu.lsu_we_i | lsu.lsu_addr_i[0];
         default: fault_in = 1'b1;
      endcase
   end

   // next-state and request latching
   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      funct3_d = funct3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      fault_d  = fault_q;
      cnt_d    = cnt_q;
      word_d   = word_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               we_d     = lsu.lsu_we_i;
               funct3_d = lsu.lsu_funct3_i;
               addr_d   = lsu.lsu_addr_i;
               wdata_d  = lsu.lsu_wdata_i;
               fault_d  = fault_in;
               word_d   = 32'h0;
               state_d  = fault_in ? S_RESP : S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (we_q) begin
               state_d = S_RESP;
            end else begin
               cnt_d   = CNT_INIT;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == 2'd0) begin
               word_d  = lsu.dmem_rdata_i;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // state register; reset abandons any access in flight
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         we_q     <= 1'b0;
         funct3_q <= 3'b000;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         fault_q  <= 1'b0;
         cnt_q    <= 2'd0;
         word_q   <= 32'h0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         fault_q  <= fault_d;
         cnt_q    <= cnt_d;
         word_q   <= word_d;
      end
   end

   // byte-enable pattern and lane replication from the latched request
   always_comb begin
      be_calc   = 4'b1111;
      lane_data = wdata_q;
      case (funct3_q[1:0])
         2'b00: begin
            be_calc   = 4'b0001 << addr_q[1:0];
            lane_data = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            be_calc   = addr_q[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{wdata_q[15:0]}};
         end
         default: begin
            be_calc   = 4'b1111;
            lane_data = wdata_q;
         end
      endcase
   end

   // pick the addressed byte/half from the captured word and extend it
   always_comb begin
      byte_v   = word_q[{addr_q[1:0], 3'b000} +: 8];
      half_v   = addr_q[1] ? word_q[31:16] : word_q[15:0];
      load_ext = word_q;
      case (funct3_q)
         3'b000:  load_ext = {{24{byte_v[7]}}, byte_v};
         3'b001:  load_ext = {{16{half_v[15]}}, half_v};
         3'b100:  load_ext = {24'h0, byte_v};
         3'b101:  load_ext = {16'h0, half_v};
         default: load_ext = word_q;
      endcase
   end

   // response and memory outputs are zero outside their own state
   always_comb begin
      lsu.lsu_rvalid_o   = (state_q == S_RESP);
      lsu.lsu_misalign_o = (state_q == S_RESP) && fault_q;
      lsu.lsu_rdata_o    = ((state_q == S_RESP) && !fault_q && !we_q) ? load_ext : 32'h0;
      lsu.dmem_req_o     = (state_q == S_ISSUE);
      lsu.dmem_wen_o     = (state_q == S_ISSUE) && we_q;
      lsu.dmem_be_o      = (state_q == S_ISSUE) ? be_calc : 4'b0000;
      lsu.dmem_addr_o    = (state_q == S_ISSUE) ? {addr_q[31:2], 2'b00} : 32'h0;
      lsu.dmem_wdata_o   = ((state_q == S_ISSUE) && we_q) ? lane_data : 32'h0;
   end

endmodule

// File: tb/tb_samsun_lsu.sv
// tb/tb_samsun_lsu.sv - directed self-checking bench for samsun_lsu at latency 1 and 3
module tb_samsun_lsu;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   samsun_lsu_if ifa();
   samsun_lsu_if ifb();

   samsun_lsu #(.DMEM_LATENCY(1)) u_lat1 (.clk_i(clk), .rst_i(rst), .lsu(ifa));
   samsun_lsu #(.DMEM_LATENCY(3)) u_lat3 (.clk_i(clk), .rst_i(rst), .lsu(ifb));

   int checks   = 0;
   int failures = 0;

   // data memories: read data is only good exactly LATENCY cycles after the request
   logic [31:0] mem_a [0:63];
   logic [31:0] mem_b [0:63];
   logic [3:0]  va = 4'h0;
   logic [3:0]  vb = 4'h0;
   logic [5:0]  ia [0:3];
   logic [5:0]  ib [0:3];

   // memory model for the latency-1 instance
   always @(posedge clk) begin
      va    <= {va[2:0], ifa.dmem_req_o & ~ifa.dmem_wen_o};
      ia[0] <= ifa.dmem_addr_o[7:2];
      for (int i = 1; i < 4; i++) ia[i] <= ia[i-1];
      if (ifa.dmem_req_o && ifa.dmem_wen_o)
         for (int i = 0; i < 4; i++)
            if (ifa.dmem_be_o[i]) mem_a[ifa.dmem_addr_o[7:2]][8*i +: 8] <= ifa.dmem_wdata_o[8*i +: 8];
   end

   // memory model for the latency-3 instance
   always @(posedge clk) begin
      vb    <= {vb[2:0], ifb.dmem_req_o & ~ifb.dmem_wen_o};
      ib[0] <= ifb.dmem_addr_o[7:2];
      for (int j = 1; j < 4; j++) ib[j] <= ib[j-1];
      if (ifb.dmem_req_o && ifb.dmem_wen_o)
         for (int j = 0; j < 4; j++)
            if (ifb.dmem_be_o[j]) mem_b[ifb.dmem_addr_o[7:2]][8*j +: 8] <= ifb.dmem_wdata_o[8*j +: 8];
   end

   assign ifa.dmem_rdata_i = va[0] ? mem_a[ia[0]] : 32'h0BAD0BAD;
   assign ifb.dmem_rdata_i = vb[2] ? mem_b[ib[2]] : 32'h0BAD0BAD;

   // outputs of whichever instance the current step talks to
   int          cur_sel = 0;
   logic        m_ready, m_rvalid, m_mis, m_req, m_wen;
   logic [31:0] m_rdata, m_addr, m_wdata;
   logic [3:0]  m_be;
   assign m_ready  = cur_sel == 1 ? ifb.lsu_ready_o    : ifa.lsu_ready_o;
   assign m_rvalid = cur_sel == 1 ? ifb.lsu_rvalid_o   : ifa.lsu_rvalid_o;
   assign m_mis    = cur_sel == 1 ? ifb.lsu_misalign_o : ifa.lsu_misalign_o;
   assign m_rdata  = cur_sel == 1 ? ifb.lsu_rdata_o    : ifa.lsu_rdata_o;
   assign m_req    = cur_sel == 1 ? ifb.dmem_req_o     : ifa.dmem_req_o;
   assign m_wen    = cur_sel == 1 ? ifb.dmem_wen_o     : ifa.dmem_wen_o;
   assign m_be     = cur_sel == 1 ? ifb.dmem_be_o      : ifa.dmem_be_o;
   assign m_addr   = cur_sel == 1 ? ifb.dmem_addr_o    : ifa.dmem_addr_o;
   assign m_wdata  = cur_sel == 1 ? ifb.dmem_wdata_o   : ifa.dmem_wdata_o;

   // observations of one transaction, latencies counted from the accept edge
   int          r_req_lat, r_nreq, r_rv_lat;
   logic [3:0]  r_be;
   logic [31:0] r_addr, r_wd, r_rd;
   logic        r_wen, r_mis;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int sel, input logic valid, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
      cur_sel          = sel;
      ifa.lsu_we_i     = we;  ifb.lsu_we_i     = we;
      ifa.lsu_funct3_i = f3;  ifb.lsu_funct3_i = f3;
      ifa.lsu_addr_i   = a;   ifb.lsu_addr_i   = a;
      ifa.lsu_wdata_i  = wd;  ifb.lsu_wdata_i  = wd;
      ifa.lsu_valid_i  = valid && (sel == 0);
      ifb.lsu_valid_i  = valid && (sel == 1);
   endtask

   task automatic run_req(input int sel, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
      int n;
      @(negedge clk);
      drive(sel, 1'b1, we, f3, a, wd);
      n = 0;
      while (!m_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("ready_before_accept", 32'(m_ready), 32'd1);
      @(posedge clk);
      r_req_lat = -1; r_nreq = 0; r_rv_lat = -1;
      r_be = 4'h0; r_addr = 32'h0; r_wd = 32'h0; r_rd = 32'h0; r_wen = 1'b0; r_mis = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         ifa.lsu_valid_i = 1'b0;
         ifb.lsu_valid_i = 1'b0;
         if (m_req) begin
            if (r_nreq == 0) begin
               r_req_lat = k; r_be = m_be; r_addr = m_addr; r_wd = m_wdata; r_wen = m_wen;
            end
            r_nreq++;
         end
         if (m_rvalid) begin
            r_rv_lat = k; r_rd = m_rdata; r_mis = m_mis;
            break;
         end
      end
   endtask

   task automatic load_case(input string tag, input int sel, input logic [2:0] f3,
                            input logic [31:0] a, input logic [3:0] be, input logic [31:0] exp_rd,
                            input int exp_lat);
      run_req(sel, 1'b0, f3, a, 32'h0);
      chk({tag, "_nreq"}, 32'(r_nreq), 32'd1);
      chk({tag, "_be"}, 32'(r_be), 32'(be));
      chk({tag, "_wen"}, 32'(r_wen), 32'd0);
      chk({tag, "_rvlat"}, 32'(r_rv_lat), 32'(exp_lat));
      chk({tag, "_rdata"}, r_rd, exp_rd);
   endtask

   task automatic store_case(input string tag, input int sel, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                             input logic [31:0] exp_wd);
      run_req(sel, 1'b1, f3, a, wd);
      chk({tag, "_reqlat"}, 32'(r_req_lat), 32'd1);
      chk({tag, "_nreq"}, 32'(r_nreq), 32'd1);
      chk({tag, "_wen"}, 32'(r_wen), 32'd1);
      chk({tag, "_be"}, 32'(r_be), 32'(be));
      chk({tag, "_addr"}, r_addr, {a[31:2], 2'b00});
      chk({tag, "_wdata"}, r_wd, exp_wd);
      chk({tag, "_rvlat"}, 32'(r_rv_lat), 32'd2);
      chk({tag, "_rdata"}, r_rd, 32'h0);
      chk({tag, "_mis"}, 32'(r_mis), 32'd0);
   endtask

   task automatic fault_case(input string tag, input logic we, input logic [2:0] f3,
                             input logic [31:0] a);
      run_req(0, we, f3, a, 32'hFFFF_FFFF);
      chk({tag, "_nreq"}, 32'(r_nreq), 32'd0);
      chk({tag, "_rvlat"}, 32'(r_rv_lat), 32'd1);
      chk({tag, "_mis"}, 32'(r_mis), 32'd1);
      chk({tag, "_rdata"}, r_rd, 32'h0);
   endtask

   int rv_seen;

   initial begin
      for (int m = 0; m < 64; m++) begin
         mem_a[m] = 32'h0;
         mem_b[m] = 32'h0;
      end
      drive(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_ready_low", 32'(ifa.lsu_ready_o), 32'd0);
      chk("reset_rvalid", 32'(ifa.lsu_rvalid_o), 32'd0);
      chk("reset_req", 32'(ifa.dmem_req_o), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_ready", 32'(ifa.lsu_ready_o), 32'd1);
      chk("idle_rdata", ifa.lsu_rdata_o, 32'h0);
      chk("idle_be", 32'(ifa.dmem_be_o), 32'd0);
      chk("idle_mis", 32'(ifa.lsu_misalign_o), 32'd0);

      // latency 1: store, then loads of every width from the stored word
      store_case("sw", 0, 3'b010, 32'h10, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
      load_case("lw", 0, 3'b010, 32'h10, 4'b1111, 32'hDEADBEEF, 3);
      chk("lw_reqlat", 32'(r_req_lat), 32'd1);
      chk("lw_addr", r_addr, 32'h10);
      load_case("lb13", 0, 3'b000, 32'h13, 4'b1000, 32'hFFFFFFDE, 3);
      load_case("lbu13", 0, 3'b100, 32'h13, 4'b1000, 32'h000000DE, 3);
      load_case("lh12", 0, 3'b001, 32'h12, 4'b1100, 32'hFFFFDEAD, 3);
      load_case("lhu10", 0, 3'b101, 32'h10, 4'b0011, 32'h0000BEEF, 3);
      load_case("lb10", 0, 3'b000, 32'h10, 4'b0001, 32'hFFFFFFEF, 3);

      // partial stores then read back the merged word
      store_case("sb11", 0, 3'b000, 32'h11, 32'h000000A5, 4'b0010, 32'hA5A5A5A5);
      store_case("sh12", 0, 3'b001, 32'h12, 32'h00001234, 4'b1100, 32'h12341234);
      load_case("lw_merged", 0, 3'b010, 32'h10, 4'b1111, 32'h1234A5EF, 3);
      load_case("lb11", 0, 3'b000, 32'h11, 4'b0010, 32'hFFFFFFA5, 3);

      // faults never reach memory and answer one cycle after accept
      fault_case("lw_mis", 1'b0, 3'b010, 32'h12);
      fault_case("sh_mis", 1'b1, 3'b001, 32'h11);
      fault_case("f3_011", 1'b0, 3'b011, 32'h10);
      fault_case("st_bu", 1'b1, 3'b100, 32'h10);
      fault_case("lhu_mis", 1'b0, 3'b101, 32'h13);

      // latency 3
      store_case("sw_l3", 1, 3'b010, 32'h10, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
      load_case("lw_l3", 1, 3'b010, 32'h10, 4'b1111, 32'hDEADBEEF, 5);
      load_case("lh_l3", 1, 3'b001, 32'h12, 4'b1100, 32'hFFFFDEAD, 5);

      // reset while a latency-3 load is waiting
      @(negedge clk);
      drive(1, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
      @(posedge clk);
      @(negedge clk);
      ifb.lsu_valid_i = 1'b0;
      chk("rst_issue_req", 32'(ifb.dmem_req_o), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_ready_low", 32'(ifb.lsu_ready_o), 32'd0);
      chk("rst_req_low", 32'(ifb.dmem_req_o), 32'd0);
      rv_seen = int'(ifb.lsu_rvalid_o);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ready_after", 32'(ifb.lsu_ready_o), 32'd1);
      for (int c = 0; c < 6; c++) begin
         rv_seen += int'(ifb.lsu_rvalid_o);
         @(negedge clk);
      end
      chk("rst_no_rvalid", 32'(rv_seen), 32'd0);
      store_case("sw_after_rst", 1, 3'b010, 32'h20, 32'h13579BDF, 4'b1111, 32'h13579BDF);
      load_case("lw_after_rst", 1, 3'b010, 32'h20, 4'b1111, 32'h13579BDF, 5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
